// File: rtl/msg_streamer.sv
// msg_streamer: multi-message character ROM with a built-in byte sequencer.
// A start pulse selects a message slot. The block then streams that slot's
// NUL-terminated text one byte per valid/ready handshake into a byte sink,
// such as a UART transmitter.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous reset, active low
//   start     one-cycle request, sampled only in IDLE
//   msg_sel   message slot index, captured with start
//   rep_mode  when set in DONE, the same message restarts from byte 0
//   abort     leaves any non-IDLE state for IDLE without a done pulse
//   tx_data   current byte (valid while tx_valid)
//   tx_valid  byte offered to the sink
//   tx_ready  sink accepts the byte on tx_valid && tx_ready at a clk edge
//   busy      high in every state except IDLE
//   done      one-cycle pulse: the message is complete
//   err       one-cycle pulse: start was given with msg_sel >= NUM_MSGS
module msg_streamer #(
    parameter int NUM_MSGS = 2,
    parameter int MSG_LEN  = 16,
    parameter int DATA_W   = 8,
    localparam int MSG_W   = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
    localparam int IDX_W   = $clog2(MSG_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MSG_W-1:0]  msg_sel,
    input  logic              rep_mode,
    input  logic              abort,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [MSG_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] rom_q;

    // Fixed message text. Every byte beyond the text reads as 0x00. This pads
    // each slot, and it leaves slots 2 and above empty. A slot shorter than its
    // text (small MSG_LEN) is cut off by the idx == MSG_LEN check in FETCH.
    function automatic logic [7:0] rom_char(input int s, input int i);
        logic [7:0] b;
        b = 8'h00;
        if (s == 0) begin
            case (i)
                0:  b = 8'h48;  // H
                1:  b = 8'h65;  // e
                2:  b = 8'h6C;  // l
                3:  b = 8'h6C;  // l
                4:  b = 8'h6F;  // o
                5:  b = 8'h20;  // ' '
                6:  b = 8'h57;  // W
                7:  b = 8'h6F;  // o
                8:  b = 8'h72;  // r
                9:  b = 8'h6C;  // l
                10: b = 8'h64;  // d
                11: b = 8'h21;  // !
                12: b = 8'h0A;
                13: b = 8'h0D;
                default: b = 8'h00;
            endcase
        end else if (s == 1) begin
            case (i)
                0: b = 8'h42;   // B
                1: b = 8'h79;   // y
                2: b = 8'h65;   // e
                3: b = 8'h21;   // !
                4: b = 8'h0A;
                5: b = 8'h0D;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    assign rom_q = DATA_W'(rom_char(int'(sel), int'(idx)));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
            idx      <= '0;
            sel      <= '0;
        end else begin
            err <= 1'b0;
            // Abort only acts while streaming. In IDLE it is ignored, so a
            // start given in the same cycle as abort is still honoured.
            if (abort && state != IDLE) begin
                state    <= IDLE;
                tx_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (32'(msg_sel) < NUM_MSGS) begin
                                sel   <= msg_sel;
                                idx   <= '0;
                                state <= FETCH;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    FETCH: begin
                        if (int'(idx) == MSG_LEN || rom_q == '0) begin
                            state <= DONE;
                        end else begin
                            tx_data  <= rom_q;
                            tx_valid <= 1'b1;
                            state    <= SEND;
                        end
                    end
                    SEND: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            idx      <= idx + IDX_W'(1);
                            state    <= FETCH;
                        end
                    end
                    default: begin  // DONE
                        if (rep_mode) begin
                            idx   <= '0;
                            state <= FETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msg_streamer.sv
module tb_msg_streamer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] msg_sel = '0;
    logic       rep_mode = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    logic [7:0] got[$];

    msg_streamer #(.NUM_MSGS(3), .MSG_LEN(16), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_sel(msg_sel),
        .rep_mode(rep_mode), .abort(abort), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Sink side: record every accepted byte.
    always @(posedge clk) begin
        if (tx_valid && tx_ready) begin
            got.push_back(tx_data);
            hs_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst_n;
        logic       start;
        logic [1:0] sel;
        logic       ready;
        logic       abort;
        logic       rep;
        logic       e_valid;
        logic [7:0] e_data;
        logic       chk_data;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t tbl[17];
    logic [7:0] msg0[14];
    logic [7:0] msg1[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc);
        for (int i = 0; i < maxc && !tx_valid; i++) tick();
        chk("wait tx_valid", int'(tx_valid), 1);
    endtask

    initial begin
        int ndone;
        int dseen;

        msg0 = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A, 8'h0D};
        msg1 = '{8'h42, 8'h79, 8'h65, 8'h21, 8'h0A, 8'h0D};

        //            rst st sel rdy ab rep  val data  cd bsy dn er
        tbl[0]  = '{1'b0, 0, 0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0}; // reset
        tbl[1]  = '{1'b1, 0, 0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0}; // idle
        tbl[2]  = '{1'b1, 1, 3, 0, 0, 0,  0, 8'h00, 0, 0, 0, 1}; // bad sel
        tbl[3]  = '{1'b1, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0};
        tbl[4]  = '{1'b1, 1, 2, 0, 0, 0,  0, 8'h00, 0, 1, 0, 0}; // empty slot
        tbl[5]  = '{1'b1, 0, 0, 0, 0, 0,  0, 8'h00, 0, 1, 1, 0}; // done, 0 bytes
        tbl[6]  = '{1'b1, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0, 0};
        tbl[7]  = '{1'b1, 1, 1, 0, 1, 0,  0, 8'h00, 0, 1, 0, 0}; // start+abort
        tbl[8]  = '{1'b1, 0, 0, 0, 0, 0,  1, 8'h42, 1, 1, 0, 0};
        tbl[9]  = '{1'b1, 0, 0, 0, 0, 0,  1, 8'h42, 1, 1, 0, 0}; // held
        tbl[10] = '{1'b1, 0, 0, 0, 1, 0,  0, 8'h00, 0, 0, 0, 0}; // abort
        tbl[11] = '{1'b1, 0, 0, 0, 1, 0,  0, 8'h00, 0, 0, 0, 0}; // abort idle
        tbl[12] = '{1'b1, 1, 0, 1, 0, 0,  0, 8'h00, 0, 1, 0, 0};
        tbl[13] = '{1'b1, 0, 0, 1, 0, 0,  1, 8'h48, 1, 1, 0, 0};
        tbl[14] = '{1'b1, 0, 0, 1, 0, 0,  0, 8'h00, 0, 1, 0, 0};
        tbl[15] = '{1'b1, 1, 1, 1, 0, 0,  1, 8'h65, 1, 1, 0, 0}; // start ignored
        tbl[16] = '{1'b0, 0, 0, 1, 0, 0,  0, 8'h00, 1, 0, 0, 0}; // mid reset

        for (int v = 0; v < 17; v++) begin
            rst_n    = tbl[v].rst_n;
            start    = tbl[v].start;
            msg_sel  = tbl[v].sel;
            tx_ready = tbl[v].ready;
            abort    = tbl[v].abort;
            rep_mode = tbl[v].rep;
            tick();
            chk($sformatf("vec%0d tx_valid", v), int'(tx_valid), int'(tbl[v].e_valid));
            if (tbl[v].chk_data)
                chk($sformatf("vec%0d tx_data", v), int'(tx_data), int'(tbl[v].e_data));
            chk($sformatf("vec%0d busy", v), int'(busy), int'(tbl[v].e_busy));
            chk($sformatf("vec%0d done", v), int'(done), int'(tbl[v].e_done));
            chk($sformatf("vec%0d err", v), int'(err), int'(tbl[v].e_err));
        end

        // Message 0 with ready held high: exact cycle timing.
        rst_n = 1'b1; start = 1'b1; msg_sel = 0; tx_ready = 1'b1; abort = 1'b0; rep_mode = 1'b0;
        got.delete(); hs_cnt = 0;
        tick();  // E0
        start = 1'b0;
        chk("t1 busy E0", int'(busy), 1);
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk($sformatf("t1 valid E%0d", e), int'(tx_valid), int'((e % 2 == 1) && e <= 27));
            if ((e % 2 == 1) && e <= 27)
                chk($sformatf("t1 data E%0d", e), int'(tx_data), int'(msg0[(e - 1) / 2]));
            chk($sformatf("t1 busy E%0d", e), int'(busy), int'(e <= 29));
            chk($sformatf("t1 done E%0d", e), int'(done), int'(e == 29));
        end
        chk("t1 handshakes", hs_cnt, 14);
        for (int k = 0; k < 14 && k < got.size(); k++)
            chk($sformatf("t1 byte%0d", k), int'(got[k]), int'(msg0[k]));

        // Backpressure on 'B'.
        got.delete(); hs_cnt = 0;
        start = 1'b1; msg_sel = 1; tx_ready = 1'b0;
        tick();
        start = 1'b0;
        wait_valid(10);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t2 hold valid", int'(tx_valid), 1);
            chk("t2 hold data", int'(tx_data), 8'h42);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) tick();
        chk("t2 done seen", int'(done), 1);
        chk("t2 handshakes", hs_cnt, 6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            chk($sformatf("t2 byte%0d", k), int'(got[k]), int'(msg1[k]));
        tick();
        chk("t2 idle", int'(busy), 0);

        // Repeat mode: two passes, then abort mid-SEND.
        got.delete(); hs_cnt = 0;
        start = 1'b1; msg_sel = 1; rep_mode = 1'b1; tx_ready = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 80 && ndone < 2; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("t4 done pulses", ndone, 2);
        chk("t4 handshakes", hs_cnt, 12);
        for (int k = 0; k < 12 && k < got.size(); k++)
            chk($sformatf("t4 byte%0d", k), int'(got[k]), int'(msg1[k % 6]));
        wait_valid(10);
        abort = 1'b1;
        tick();
        abort = 1'b0; rep_mode = 1'b0;
        chk("t4 abort valid", int'(tx_valid), 0);
        chk("t4 abort busy", int'(busy), 0);
        dseen = int'(done);
        for (int i = 0; i < 3; i++) begin
            tick();
            dseen |= int'(done);
        end
        chk("t4 no done after abort", dseen, 0);
        chk("t4 stays idle", int'(busy), 0);

        // Reset during SEND of byte 5, then restart from 'H'.
        start = 1'b1; msg_sel = 0; tx_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 11; e++) tick();
        chk("t5 byte5 valid", int'(tx_valid), 1);
        chk("t5 byte5 data", int'(tx_data), 8'h20);
        rst_n = 1'b0; tx_ready = 1'b0;
        tick();
        chk("t5 rst valid", int'(tx_valid), 0);
        chk("t5 rst data", int'(tx_data), 0);
        chk("t5 rst busy", int'(busy), 0);
        chk("t5 rst done", int'(done), 0);
        chk("t5 rst err", int'(err), 0);
        rst_n = 1'b1; start = 1'b1; msg_sel = 0;
        tick();
        start = 1'b0;
        tick();
        chk("t5 restart valid", int'(tx_valid), 1);
        chk("t5 restart data", int'(tx_data), 8'h48);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
